// File: rtl/seg_scan_if.sv
// Bus bundle for the 7-segment scan scheduler.
// Writer side: wr_en/wr_addr/wr_data load the digit buffer, dig_en masks digits.
// Display side: segment (active-low, bit7 = dp), seg_sel (active-low digit select),
// frame_done (one-cycle pulse when the scan wraps).
interface seg_scan_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic [7:0] dig_en;
    logic [7:0] segment;
    logic [7:0] seg_sel;
    logic       frame_done;

    modport master (
        output wr_en, wr_addr, wr_data, dig_en,
        input  segment, seg_sel, frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, dig_en,
        output segment, seg_sel, frame_done
    );
endinterface

// File: rtl/seg_scan_sched.sv
// Round-robin scan scheduler for an 8-digit common-anode 7-segment display.
// Ports: clk, rst_n (synchronous, active-low), bus (seg_scan_if.slave):
//   wr_en/wr_addr/wr_data write the 8-entry digit buffer ({dp, hex}),
//   dig_en selects which digits are scanned, segment/seg_sel drive the display,
//   frame_done pulses on the SHOW entry that wraps back to a lower index.
module seg_scan_sched #(
    parameter int unsigned SCAN_CYC  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_if.slave     bus
);

    localparam int unsigned CNT_MAX = ((SCAN_CYC > BLANK_CYC) ? SCAN_CYC : BLANK_CYC) - 1;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         ptr_q, ptr_d;
    logic               first_q, first_d;
    logic [7:0]         seg_q, seg_d;
    logic [7:0]         sel_q, sel_d;
    logic               fd_q, fd_d;
    logic [4:0]         digit_mem [8];
    logic [2:0]         next_idx;

    // Hex to active-low segments, bit order g,f,e,d,c,b,a.
    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;
            4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;
            4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;
            default: decode = 7'h0E;
        endcase
    endfunction

    function automatic logic [7:0] seg_of(input logic [4:0] e);
        seg_of = {~e[4], decode(e[3:0])};
    endfunction

    // Next digit to show: lowest enabled after reset/idle, else first enabled after ptr.
    // Loops run from far to near so the nearest match is the last assignment.
    always_comb begin
        next_idx = ptr_q;
        if (first_q) begin
            for (int i = 7; i >= 0; i--) begin
                if (bus.dig_en[i]) next_idx = 3'(i);
            end
        end else begin
            for (int k = 8; k >= 1; k--) begin
                if (bus.dig_en[3'(ptr_q + 3'(k))]) next_idx = 3'(ptr_q + 3'(k));
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        ptr_d   = ptr_q;
        first_d = first_q;
        seg_d   = 8'hff;
        sel_d   = 8'hff;
        fd_d    = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYC - 1)) begin
                    cnt_d = '0;
                    if (bus.dig_en != 8'h00) begin
                        state_d = SHOW;
                        ptr_d   = next_idx;
                        first_d = 1'b0;
                        fd_d    = !first_q && (next_idx <= ptr_q);
                        seg_d   = seg_of(digit_mem[next_idx]);
                        sel_d   = ~(8'h01 << next_idx);
                    end else begin
                        // Nothing enabled: stay dark and restart selection from the lowest index.
                        first_d = 1'b1;
                    end
                end
            end
            SHOW: begin
                if (cnt_q == CNT_W'(SCAN_CYC - 1)) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end else begin
                    // Reloaded every cycle so buffer writes show up on the next edge.
                    seg_d = seg_of(digit_mem[ptr_q]);
                    sel_d = ~(8'h01 << ptr_q);
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // State, buffer and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            ptr_q   <= '0;
            first_q <= 1'b1;
            seg_q   <= 8'hff;
            sel_q   <= 8'hff;
            fd_q    <= 1'b0;
            for (int i = 0; i < 8; i++) digit_mem[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            first_q <= first_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            fd_q    <= fd_d;
            if (bus.wr_en) digit_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.segment    = seg_q;
    assign bus.seg_sel    = sel_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Directed bench for seg_scan_sched with SCAN_CYC = 4, BLANK_CYC = 2.
module tb_seg_scan_sched;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    seg_scan_if bus ();

    seg_scan_sched #(
        .SCAN_CYC  (4),
        .BLANK_CYC (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_sel"}, bus.seg_sel, 8'hff);
        check({tag, "_seg"}, bus.segment, 8'hff);
        check({tag, "_fd"}, 8'(bus.frame_done), 8'h00);
    endtask

    // Called at the negedge right after a SHOW entry; returns at the next entry's negedge.
    task automatic check_slot(input logic [7:0] sel, input logic [7:0] seg, input logic fd);
        string t;
        t = $sformatf("slot_%h", sel);
        check({t, "_sel"}, bus.seg_sel, sel);
        check({t, "_seg"}, bus.segment, seg);
        check({t, "_fd_entry"}, 8'(bus.frame_done), 8'(fd));
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check({t, "_sel_hold"}, bus.seg_sel, sel);
            check({t, "_seg_hold"}, bus.segment, seg);
            check({t, "_fd_hold"}, 8'(bus.frame_done), 8'h00);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_dark({t, "_gap"});
        end
        @(negedge clk);
    endtask

    task automatic wait_sel(input logic [7:0] sel, input string tag);
        int n;
        n = 0;
        while (bus.seg_sel !== sel && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.seg_sel, sel);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 3'd0;
        bus.wr_data = 5'h00;
        bus.dig_en  = 8'hff;

        // 1. Reset, then first slot on digit 0.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_dark("reset");
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_dark("post_reset_blank");
        @(negedge clk);
        check_slot(8'hfe, 8'hC0, 1'b0);

        // 2. Load entry[k] = k (entry[3] with dp), then verify full round order.
        for (int k = 0; k < 8; k++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 3'(k);
            bus.wr_data = (k == 3) ? 5'h13 : 5'(k);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        wait_sel(8'hfe, "sync_fe");
        check_slot(8'hfe, 8'hC0, 1'b1);
        check_slot(8'hfd, 8'hF9, 1'b0);
        check_slot(8'hfb, 8'hA4, 1'b0);
        check_slot(8'hf7, 8'h30, 1'b0);
        check_slot(8'hef, 8'h99, 1'b0);
        check_slot(8'hdf, 8'h92, 1'b0);
        check_slot(8'hbf, 8'h82, 1'b0);
        check_slot(8'h7f, 8'hF8, 1'b0);
        check_slot(8'hfe, 8'hC0, 1'b1);

        // 3. Sparse mask 0,2,5 (changed while digit 1 is showing).
        bus.dig_en = 8'b0010_0101;
        check_slot(8'hfd, 8'hF9, 1'b0);
        check_slot(8'hfb, 8'hA4, 1'b0);
        check_slot(8'hdf, 8'h92, 1'b0);
        check_slot(8'hfe, 8'hC0, 1'b1);
        check_slot(8'hfb, 8'hA4, 1'b0);
        check_slot(8'hdf, 8'h92, 1'b0);
        check_slot(8'hfe, 8'hC0, 1'b1);

        // 4. Idle, then single digit 7.
        bus.dig_en = 8'h00;
        for (int i = 0; i < 6; i++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            check_dark("idle");
            @(negedge clk);
        end
        bus.dig_en = 8'h80;
        wait_sel(8'h7f, "sync_7f");
        check_slot(8'h7f, 8'hF8, 1'b0);
        check_slot(8'h7f, 8'hF8, 1'b1);
        check_slot(8'h7f, 8'hF8, 1'b1);

        // 5. Live update of digit 1 while shown.
        bus.dig_en = 8'h02;
        check_slot(8'h7f, 8'hF8, 1'b1);
        check("live_sel", bus.seg_sel, 8'hfd);
        check("live_seg_old", bus.segment, 8'hF9);
        check("live_fd_wrap", 8'(bus.frame_done), 8'h01);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd1;
        bus.wr_data = 5'h0A;
        @(negedge clk);
        check("live_seg_before", bus.segment, 8'hF9);
        bus.wr_data = 5'h1F;
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("live_seg_A", bus.segment, 8'h88);
        @(negedge clk);
        check("live_seg_F_dp", bus.segment, 8'h0E);
        check("live_sel_hold", bus.seg_sel, 8'hfd);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_dark("live_gap");
        end
        @(negedge clk);
        check_slot(8'hfd, 8'h0E, 1'b1);

        // 6. Reset in the middle of digit 5's slot, with a concurrent write.
        bus.dig_en = 8'h20;
        check_slot(8'hfd, 8'h0E, 1'b1);
        check("pre_rst_sel", bus.seg_sel, 8'hdf);
        check("pre_rst_seg", bus.segment, 8'h92);
        check("pre_rst_fd", 8'(bus.frame_done), 8'h00);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd5;
        bus.wr_data = 5'h1F;
        @(negedge clk);
        check_dark("mid_reset");
        rst_n      = 1'b1;
        bus.wr_en  = 1'b0;
        bus.dig_en = 8'hff;
        @(negedge clk);
        check_dark("post_mid_reset_blank");
        @(negedge clk);
        check_slot(8'hfe, 8'hC0, 1'b0);
        check_slot(8'hfd, 8'hC0, 1'b0);
        check_slot(8'hfb, 8'hC0, 1'b0);
        check_slot(8'hf7, 8'hC0, 1'b0);
        check_slot(8'hef, 8'hC0, 1'b0);
        check_slot(8'hdf, 8'hC0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
